nist_block_ctrl: RTL and testbench
==================================

Name: nist_block_ctrl

Overview:
- Sequencer for the NIST randomness-test datapath inside the tt_um_maxluppe_NIST top.
- Takes a serial bit stream and collects one block of 2^LOG_N bits.
- Evaluates the SP 800-22 monobit (frequency) criterion and the runs criterion on that block.
- Serialises a 5-byte result record onto the shared 8-bit output bus using a valid/ready handshake.

Parameters:
- LOG_N, 8: log2 of block length in bits; legal range 2..15, so N = 2^LOG_N.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new block; honoured only in IDLE.
- abort  in  1  return to IDLE from any state on the next edge; no done pulse.
- bit_in  in  1  sample bit.
- bit_valid  in  1  bit_in is valid this cycle.
- mono_tol  in  LOG_N+1  monobit tolerance: pass if |2*ones − N| <= mono_tol.
- runs_lo  in  16  minimum run count for pass (inclusive).
- runs_hi  in  16  maximum run count for pass (inclusive).
- out_data  out  8  result byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in COLLECT, EVAL and REPORT.
- done  out  1  one-cycle pulse after the last byte is accepted.
- pass  out  1  overall verdict (both tests passed); held until the next start.

Behaviour:
- Reset values: state=IDLE, counters=0, out_data=0, out_valid=0, busy=0, done=0, pass=0.
- Config inputs (mono_tol, runs_lo, runs_hi) are sampled into registers on start and are ignored mid-block.
- IDLE:
  - start=1 → COLLECT next cycle.
  - On entry to COLLECT: ones=0, bitcnt=0, runs=0, pass=0.
- COLLECT:
  - Each cycle with bit_valid=1 accepts one bit and increments bitcnt.
  - ones += bit_in.
  - First bit: runs=1 and prev=bit_in. Later bits: runs += (bit_in != prev), then prev=bit_in.
  - bit_valid=0 stalls with no state change.
  - When the N-th bit is accepted → EVAL on the next cycle. Bits presented in EVAL or REPORT are dropped.
- EVAL (exactly 1 cycle):
  - mono_ok = |2*ones − N| <= mono_tol, computed at LOG_N+2 bits signed; no overflow permitted.
  - runs_ok = runs_lo <= runs <= runs_hi, unsigned 16-bit compare.
  - runs_lo > runs_hi forces runs_ok=0.
  - pass <= mono_ok & runs_ok. Load the byte index to 0. → REPORT.
- REPORT:
  - Presents 5 bytes in order:
    - byte 0: {mono_ok, runs_ok, 2'b00, LOG_N[3:0]}
    - byte 1: ones[15:8]
    - byte 2: ones[7:0]
    - byte 3: runs[15:8]
    - byte 4: runs[7:0]
  - ones is zero-extended to 16 bits.
  - out_valid=1 throughout REPORT. out_data must stay stable while out_valid=1 and out_ready=0.
  - The byte advances on out_valid & out_ready.
  - Byte 4 accepted → IDLE, with done=1 for that next cycle and out_valid=0.
- Latency: last bit accepted at cycle t → out_valid first high at t+2. With out_ready held at 1, done is high at t+7.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Reset asserted mid-operation: all outputs immediately return to their reset values, with no partial record.
- Counter widths:
  - ones: LOG_N+1 bits (max N).
  - bitcnt: LOG_N+1 bits.
  - runs: 16 bits, saturating is unnecessary because runs <= N <= 32768.

Decomposition:
- Package nist_pkg holds:
  - state enum {IDLE, COLLECT, EVAL, REPORT};
  - REC_BYTES=5;
  - status-byte bit positions (MONO_OK_BIT=7, RUNS_OK_BIT=6).
- One sub-module, nist_bit_stats: ones/runs/bitcnt counters with clear and enable, and a last_bit flag.
- The FSM, evaluation and serialiser stay in nist_block_ctrl.

Test Plan (LOG_N=8):
1. 256 ones, mono_tol=16, runs 100..156 → bytes 0x08,0x01,0x00,0x00,0x01; pass=0; done pulses once.
2. Alternating 0,1,… (256 bits), mono_tol=0, runs 1..256 → ones=128, runs=256; status 0xC8; pass=1.
3. Pattern 0,0,1,1 repeated, runs 100..156, mono_tol=0 → ones=128, runs=128; status 0xC8. Then runs_lo=200, runs_hi=100 → status 0x88, pass=0.
4. Backpressure: out_ready toggled 1 cycle on / 3 cycles off during scenario 2 → each byte held stable until accepted; exactly 5 transfers; out_valid first high 2 cycles after the last bit.
5. bit_valid gaps (random 50%) plus start pulses during COLLECT → identical result to gap-free run; extra starts have no effect.
6. rst asserted (asynchronously, mid-cycle) after 100 bits, then a normal block; abort during REPORT → outputs zero at once, busy=0, no done; the next block reports only the new data.

Source files
------------

// File: rtl/nist_block_ctrl_pkg.sv
// Shared types and constants for the NIST block sequencer.
// Holds the FSM state type and the result record layout.
package nist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL,
    REPORT
  } state_t;

  localparam int REC_BYTES   = 5;
  localparam int MONO_OK_BIT = 7;
  localparam int RUNS_OK_BIT = 6;

  function automatic logic [7:0] status_byte(
    input logic       mono,
    input logic       runs,
    input logic [3:0] log_n
  );
    logic [7:0] s;
    s = {4'h0, log_n};
    s[MONO_OK_BIT] = mono;
    s[RUNS_OK_BIT] = runs;
    return s;
  endfunction

endpackage

// File: rtl/nist_block_ctrl_if.sv
// Serial bit input and 8-bit result bus of the NIST sequencer.
// The sequencer is the slave; the producer/consumer side is the master.
interface nist_block_ctrl_if;

  logic       bit_in;
  logic       bit_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output bit_in, bit_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  bit_in, bit_valid, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/nist_block_ctrl_bit_stats.sv
// Ones / runs / bit counters over one block of 2^LOG_N bits.
// last_bit flags that the bit accepted this cycle completes the block.
module nist_bit_stats #(
  parameter int LOG_N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           bit_in,
  output logic [LOG_N:0] ones,
  output logic [15:0]    runs,
  output logic           last_bit
);

  localparam logic [LOG_N:0] LAST =
    (LOG_N+1)'((1 << LOG_N) - 1);

  logic [LOG_N:0] bitcnt;
  logic           prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones   <= '0;
      bitcnt <= '0;
      runs   <= '0;
      prev   <= 1'b0;
    end else if (clr) begin
      ones   <= '0;
      bitcnt <= '0;
      runs   <= '0;
      prev   <= 1'b0;
    end else if (en) begin
      ones   <= ones + {{LOG_N{1'b0}}, bit_in};
      bitcnt <= bitcnt + {{LOG_N{1'b0}}, 1'b1};
      prev   <= bit_in;
      if (bitcnt == '0)
        runs <= 16'd1;
      else
        runs <= runs + {15'd0, bit_in ^ prev};
    end
  end

  assign last_bit = en & (bitcnt == LAST);

endmodule

// File: rtl/nist_block_ctrl.sv
// Block sequencer: collect 2^LOG_N bits, judge monobit and runs,
// then stream a 5-byte result record over a valid/ready bus.
module nist_block_ctrl
  import nist_pkg::*;
#(
  parameter int LOG_N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LOG_N:0]    mono_tol,
  input  logic [15:0]       runs_lo,
  input  logic [15:0]       runs_hi,
  nist_block_ctrl_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam int W = LOG_N + 2;
  localparam logic [2:0] LAST_IDX = 3'(REC_BYTES - 1);

  state_t         state, state_nx;
  logic [LOG_N:0] tol_q;
  logic [15:0]    lo_q, hi_q;
  logic           mono_ok, runs_ok;
  logic [2:0]     idx;

  logic [LOG_N:0] ones;
  logic [15:0]    runs, ones16;
  logic           last_bit;
  logic           clr, en, acc, begin_blk;

  logic [W-1:0]   diff, mag;
  logic           mono_c, runs_c;

  nist_bit_stats #(.LOG_N(LOG_N)) u_stats (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (en),
    .bit_in   (bus.bit_in),
    .ones     (ones),
    .runs     (runs),
    .last_bit (last_bit)
  );

  assign begin_blk = (state == IDLE) & start & ~abort;
  assign acc       = bus.out_valid & bus.out_ready;
  assign ones16    = 16'(ones);

  // 2*ones - N wraps harmlessly: the true result lies in [-N, N]
  assign diff   = {ones, 1'b0} - (W'(1) << LOG_N);
  assign mag    = diff[W-1] ? (~diff + W'(1)) : diff;
  assign mono_c = mag <= {1'b0, tol_q};
  assign runs_c = (lo_q <= hi_q) & (runs >= lo_q) & (runs <= hi_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start)    state_nx = COLLECT;
        COLLECT: if (last_bit) state_nx = EVAL;
        EVAL:                  state_nx = REPORT;
        REPORT:  if (acc && idx == LAST_IDX)
                   state_nx = IDLE;
        default:               state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = state != IDLE;
    bus.out_valid = state == REPORT;
    clr           = begin_blk;
    en            = (state == COLLECT) & bus.bit_valid;
    bus.out_data  = 8'h00;
    if (state == REPORT) begin
      unique case (idx)
        3'd0:    bus.out_data =
                   status_byte(mono_ok, runs_ok, 4'(LOG_N));
        3'd1:    bus.out_data = ones16[15:8];
        3'd2:    bus.out_data = ones16[7:0];
        3'd3:    bus.out_data = runs[15:8];
        3'd4:    bus.out_data = runs[7:0];
        default: bus.out_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tol_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mono_ok <= 1'b0;
      runs_ok <= 1'b0;
      pass    <= 1'b0;
      idx     <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == REPORT) & acc &
              (idx == LAST_IDX) & ~abort;
      if (begin_blk) begin
        tol_q <= mono_tol;
        lo_q  <= runs_lo;
        hi_q  <= runs_hi;
        pass  <= 1'b0;
      end
      if (state == EVAL) begin
        mono_ok <= mono_c;
        runs_ok <= runs_c;
        pass    <= mono_c & runs_c;
        idx     <= '0;
      end else if (state == REPORT && acc) begin
        idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_nist_block_ctrl.sv
// Scoreboard bench for nist_block_ctrl with a counting reference model.
// Driver pushes expected bytes; a negedge monitor pops and compares.
module tb_nist_block_ctrl;

  localparam int LOG_N = 8;
  localparam int N     = 256;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [8:0]  mono_tol;
  logic [15:0] runs_lo, runs_hi;
  logic        busy, done, pass;

  nist_block_ctrl_if bus();

  nist_block_ctrl #(.LOG_N(LOG_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .mono_tol (mono_tol),
    .runs_lo  (runs_lo),
    .runs_hi  (runs_hi),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .pass     (pass)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic       exp_pass = 1'b0;
  logic       blk[$];
  int done_cnt = 0, xfer_cnt = 0;
  int first_valid_cyc = 0, done_cyc = 0;
  int rdy_mode = 0;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte
  initial begin
    logic       prev_valid, prev_stall;
    logic [7:0] prev_data;
    prev_valid = 0; prev_stall = 0; prev_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
        prev_stall = 0;
      end else begin
        if (bus.out_valid && !prev_valid)
          first_valid_cyc = cyc;
        if (bus.out_valid && prev_stall)
          check("hold_stable", bus.out_data, prev_data);
        if (bus.out_valid && bus.out_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_byte: got %0h expected none",
                     bus.out_data);
          end else begin
            check("byte", bus.out_data, exp_q.pop_front());
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("pass_at_done", pass, exp_pass);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_valid = bus.out_valid;
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = (cyc % 4 == 0);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  task automatic fill(int kind);
    blk.delete();
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       blk.push_back(1'b1);
        1:       blk.push_back(1'(i % 2));
        2:       blk.push_back(1'((i / 2) % 2));
        default: blk.push_back(1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  // Reference: count ones and value changes, then apply the criteria
  task automatic model_push(int tol, int lo, int hi);
    int ones, runs, dev;
    logic mo, ro;
    ones = 0;
    runs = 0;
    foreach (blk[i]) begin
      ones += int'(blk[i]);
      if (i == 0 || blk[i] != blk[i-1]) runs++;
    end
    dev = 2 * ones - N;
    if (dev < 0) dev = -dev;
    mo = dev <= tol;
    ro = (runs >= lo) && (runs <= hi);
    exp_q.push_back({mo, ro, 2'b00, 4'(LOG_N)});
    exp_q.push_back(8'(ones >> 8));
    exp_q.push_back(8'(ones));
    exp_q.push_back(8'(runs >> 8));
    exp_q.push_back(8'(runs));
    exp_pass = mo & ro;
  endtask

  task automatic do_start(int tol, int lo, int hi);
    mono_tol = 9'(tol);
    runs_lo  = 16'(lo);
    runs_hi  = 16'(hi);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_bits(int gap, logic noise, output int t_last);
    t_last = 0;
    foreach (blk[i]) begin
      while ($urandom_range(0, 99) < gap) begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'($urandom_range(0, 1));
        start = noise & 1'($urandom_range(0, 1));
        if (noise) begin
          mono_tol = 9'($urandom);
          runs_lo  = 16'($urandom);
          runs_hi  = 16'($urandom);
        end
        @(posedge clk); #1;
      end
      bus.bit_valid = 1'b1;
      bus.bit_in    = blk[i];
      start  = noise & 1'($urandom_range(0, 1));
      t_last = cyc;
      @(posedge clk); #1;
    end
    bus.bit_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_block(int tol, int lo, int hi, int gap,
                           logic noise, logic chk_lat);
    int x0, d0, t_last, k;
    x0 = xfer_cnt;
    d0 = done_cnt;
    model_push(tol, lo, hi);
    do_start(tol, lo, hi);
    drive_bits(gap, noise, t_last);
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      if (noise) begin
        bus.bit_valid = 1'($urandom_range(0, 1));
        bus.bit_in    = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      k++;
    end
    bus.bit_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("done_once", done_cnt - d0, 1);
    check("xfers", xfer_cnt - x0, 5);
    check("queue_drained", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    check("pass_held", pass, exp_pass);
    if (chk_lat) begin
      check("valid_latency", first_valid_cyc - t_last, 2);
      if (rdy_mode == 0)
        check("done_latency", done_cyc - t_last, 7);
    end
    exp_q.delete();
  endtask

  task automatic check_idle_zero(string nm);
    check({nm, "_valid"}, bus.out_valid, 0);
    check({nm, "_data"}, bus.out_data, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
  endtask

  initial begin
    int k, x0, d0, t_last;
    logic [31:0] r;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    mono_tol = '0; runs_lo = '0; runs_hi = '0;
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    check("reset_pass", pass, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill(0); run_block(16, 100, 156, 0, 1'b0, 1'b1);
    fill(1); run_block(0, 1, 256, 0, 1'b0, 1'b1);
    fill(2); run_block(0, 100, 156, 0, 1'b0, 1'b1);
    run_block(0, 200, 100, 0, 1'b0, 1'b1);

    rdy_mode = 1;
    fill(1); run_block(0, 1, 256, 0, 1'b0, 1'b1);
    rdy_mode = 0;

    fill(3); run_block(20, 100, 156, 0, 1'b0, 1'b1);
    rdy_mode = 2;
    run_block(20, 100, 156, 50, 1'b1, 1'b0);
    rdy_mode = 0;

    for (int i = 0; i < 4; i++) begin
      fill(3);
      rdy_mode = $urandom_range(0, 2);
      r = $urandom_range(110, 140);
      run_block($urandom_range(0, 40), int'(r) - 10,
                int'(r) + $urandom_range(0, 20),
                $urandom_range(0, 30), 1'b0, 1'b1);
    end
    rdy_mode = 0;

    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);

    fill(1); run_block(0, 1, 256, 0, 1'b0, 1'b1);
    do_start(0, 0, 300);
    for (int i = 0; i < 100; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_idle_zero("midrst");
    check("midrst_pass", pass, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill(2); run_block(0, 100, 156, 0, 1'b0, 1'b1);

    fill(1);
    rdy_mode = 1;
    x0 = xfer_cnt;
    model_push(0, 1, 256);
    do_start(0, 1, 256);
    drive_bits(0, 1'b0, t_last);
    k = 0;
    while (xfer_cnt - x0 < 2 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_reached_report", busy, 1);
    d0 = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_idle_zero("abort");
    exp_q.delete();
    repeat (10) begin @(posedge clk); #1; end
    check("abort_no_done", done_cnt - d0, 0);
    rdy_mode = 0;
    fill(0); run_block(16, 100, 156, 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
